// File: rtl/pack_nto16_pkg.sv
// pack_nto16_pkg
//   Shared constants for the pixel packer: data-type token codes, packing
//   mode encodings, the pixel-width table, header image_type codes and the
//   controller state type.
//   No ports (package).
package pack_nto16_pkg;

  localparam int DTYPE_WIDTH = 4;
  typedef logic [DTYPE_WIDTH-1:0] dtype_t;

  // Control tokens use codes below 8; any code with bit 3 set is a pixel.
  localparam dtype_t DTYPE_FRAME_START  = 4'h1;
  localparam dtype_t DTYPE_FRAME_END    = 4'h2;
  localparam dtype_t DTYPE_HEADER_START = 4'h3;
  localparam dtype_t DTYPE_HEADER_END   = 4'h4;
  localparam dtype_t DTYPE_HEADER       = 4'h5;
  localparam dtype_t DTYPE_PIXEL        = 4'h8;
  localparam dtype_t DTYPE_PIXEL_MASK   = 4'h8;

  // Header word index carrying the image_type field.
  localparam int IMAGE_IMAGE_TYPE = 3;

  typedef enum logic [1:0] {
    PACK_MODE_BYPASS = 2'd0,
    PACK_MODE_10     = 2'd1,
    PACK_MODE_12     = 2'd2,
    PACK_MODE_14     = 2'd3
  } pack_mode_e;

  localparam logic [4:0] PACK_IMGTYPE_10 = 5'h11;
  localparam logic [4:0] PACK_IMGTYPE_12 = 5'h10;
  localparam logic [4:0] PACK_IMGTYPE_14 = 5'h12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_HEADER = 2'd2
  } state_e;

  // Pixel width in bits for a packing mode; bypass has no packed width.
  function automatic logic [4:0] pack_bits(input logic [1:0] mode);
    case (mode)
      PACK_MODE_10: pack_bits = 5'd10;
      PACK_MODE_12: pack_bits = 5'd12;
      PACK_MODE_14: pack_bits = 5'd14;
      default:      pack_bits = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] pack_imgtype(input logic [1:0] mode);
    case (mode)
      PACK_MODE_10: pack_imgtype = PACK_IMGTYPE_10;
      PACK_MODE_12: pack_imgtype = PACK_IMGTYPE_12;
      PACK_MODE_14: pack_imgtype = PACK_IMGTYPE_14;
      default:      pack_imgtype = 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/pack_nto16_if.sv
// pack_nto16_if
//   Streaming bus between the imager pipeline and the packer, plus the
//   packer's 16-bit output towards the host channel.
//   Signals: dvi/dtypei/datai (into the packer), dvo/dtypeo/datao (out).
//   Modports: master = upstream/test side, slave = packer.
interface pack_nto16_if;
  import pack_nto16_pkg::*;

  logic        dvi;
  dtype_t      dtypei;
  logic [15:0] datai;
  logic        dvo;
  dtype_t      dtypeo;
  logic [15:0] datao;

  modport master (output dvi, dtypei, datai, input dvo, dtypeo, datao);
  modport slave  (input dvi, dtypei, datai, output dvo, dtypeo, datao);
endinterface

// File: rtl/pack_nto16_bit_accum.sv
// pack_nto16_bit_accum
//   MSB-first bit accumulator: 32-bit shift buffer with a 5-bit count of
//   pending bits. Pending bits are kept left-justified so the top 16 bits
//   are always the next output word and unused low bits stay zero.
//   Ports:
//     clk, resetb      clock, asynchronous active-low reset
//     push             append data[width-1:0] below the pending bits
//     width            pixel width (10/12/14)
//     data             right-justified pixel
//     flush            present pending bits as a zero-padded word, then empty
//     clear            discard pending bits
//     word, word_valid next 16-bit word (combinational) and its qualifier
//     residual         number of pending bits
module pack_nto16_bit_accum (
  input  logic        clk,
  input  logic        resetb,
  input  logic        push,
  input  logic [4:0]  width,
  input  logic [15:0] data,
  input  logic        flush,
  input  logic        clear,
  output logic [15:0] word,
  output logic        word_valid,
  output logic [4:0]  residual
);

  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] masked, placed, merged;
  logic [4:0]  sum;

  always_comb begin
    masked     = {16'h0, data} & ((32'd1 << width) - 32'd1);
    // Left-justify the new pixel, then slide it under the pending bits.
    placed     = (masked << (6'd32 - {1'b0, width})) >> cnt_q;
    merged     = acc_q | placed;
    // Residual never exceeds 15 and width never exceeds 14, so 5 bits suffice.
    sum        = cnt_q + width;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    word       = acc_q[31:16];
    word_valid = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (flush) begin
      word_valid = (cnt_q != 5'd0);
      acc_d      = '0;
      cnt_d      = '0;
    end else if (push) begin
      word = merged[31:16];
      if (sum >= 5'd16) begin
        word_valid = 1'b1;
        acc_d      = merged << 16;
        cnt_d      = sum - 5'd16;
      end else begin
        acc_d = merged;
        cnt_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign residual = cnt_q;

endmodule

// File: rtl/pack_nto16.sv
// pack_nto16
//   Runtime-selectable pixel packer: packs 10/12/14-bit pixels MSB-first into
//   contiguous 16-bit words, pads and flushes a partial word at frame end,
//   and optionally rewrites the header image_type field for the packed mode.
//   Build option: define PACK_HDR_REWRITE_EN to enable the header
//   image_type rewrite; without it header words pass unmodified.
//   Ports:
//     clk, resetb   clock, asynchronous active-low reset
//     enable        packing enable from another clock domain (synchronised)
//     pack_mode     0=bypass 1=10b 2=12b 3=14b, latched at FRAME_START
//     bus           pack_nto16_if.slave: dvi/dtypei/datai in, dvo/dtypeo/datao out
//     frame_count   FRAME_START tokens seen (wraps)
//     active_mode   mode latched for the current frame
//     overflow      sticky hold-register collision flag
module pack_nto16
  import pack_nto16_pkg::*;
#(
  parameter int HDR_IMGTYPE_ADDR = IMAGE_IMAGE_TYPE,
  parameter int HDR_ADDR_WIDTH   = 6,
  parameter int FC_WIDTH         = 16
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                enable,
  input  logic [1:0]          pack_mode,
  pack_nto16_if.slave         bus,
  output logic [FC_WIDTH-1:0] frame_count,
  output logic [1:0]          active_mode,
  output logic                overflow
);

  if (HDR_IMGTYPE_ADDR >= (1 << HDR_ADDR_WIDTH)) begin : g_addr_range
    $error("HDR_IMGTYPE_ADDR does not fit in HDR_ADDR_WIDTH");
  end

  logic                en_s1_q, en_s2_q;
  state_e              state_q;
  logic [1:0]          mode_q;
  logic [FC_WIDTH-1:0] fc_q;
  logic                ovf_q;
  logic                dvo_q;
  dtype_t              dtypeo_q;
  logic [15:0]         datao_q;
  logic                hold_vld_q;
  dtype_t              hold_dtype_q;
  logic [15:0]         hold_data_q;
  dtype_t              pix_dtype_q;

  // While the hold register drains, the incoming beat is dropped entirely.
  logic in_ok, is_fs, is_fe, is_hs, is_he, is_pix;
  logic acc_push, acc_flush, acc_clear, acc_word_vld;
  logic [15:0] acc_word;
  logic [4:0]  acc_residual;

  assign in_ok  = bus.dvi && !hold_vld_q;
  assign is_fs  = in_ok && (bus.dtypei == DTYPE_FRAME_START);
  assign is_fe  = in_ok && (bus.dtypei == DTYPE_FRAME_END);
  assign is_hs  = in_ok && (bus.dtypei == DTYPE_HEADER_START);
  assign is_he  = in_ok && (bus.dtypei == DTYPE_HEADER_END);
  assign is_pix = in_ok && ((bus.dtypei & DTYPE_PIXEL_MASK) != '0);

  assign acc_push  = is_pix && (state_q == ST_FRAME) && (mode_q != PACK_MODE_BYPASS);
  assign acc_flush = is_fe && (acc_residual != 5'd0);
  assign acc_clear = is_fs;

`ifdef PACK_HDR_REWRITE_EN
  logic [HDR_ADDR_WIDTH-1:0] hdr_addr_q;
  logic is_hdr, hdr_rw;
  assign is_hdr = in_ok && (bus.dtypei == DTYPE_HEADER);
  // Mode comes from the previous FRAME_START: the header describes that frame.
  assign hdr_rw = is_hdr && (state_q == ST_HEADER) && (mode_q != PACK_MODE_BYPASS) &&
                  (hdr_addr_q == HDR_ADDR_WIDTH'(HDR_IMGTYPE_ADDR));
`endif

  pack_nto16_bit_accum u_accum (
    .clk        (clk),
    .resetb     (resetb),
    .push       (acc_push),
    .width      (pack_bits(mode_q)),
    .data       (bus.datai),
    .flush      (acc_flush),
    .clear      (acc_clear),
    .word       (acc_word),
    .word_valid (acc_word_vld),
    .residual   (acc_residual)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      en_s1_q      <= 1'b0;
      en_s2_q      <= 1'b0;
      state_q      <= ST_IDLE;
      mode_q       <= PACK_MODE_BYPASS;
      fc_q         <= '0;
      ovf_q        <= 1'b0;
      dvo_q        <= 1'b0;
      dtypeo_q     <= '0;
      datao_q      <= '0;
      hold_vld_q   <= 1'b0;
      hold_dtype_q <= '0;
      hold_data_q  <= '0;
      pix_dtype_q  <= '0;
`ifdef PACK_HDR_REWRITE_EN
      hdr_addr_q   <= '0;
`endif
    end else begin
      en_s1_q    <= enable;
      en_s2_q    <= en_s1_q;
      // Default: pass the input through with one cycle of latency.
      dvo_q      <= bus.dvi;
      dtypeo_q   <= bus.dtypei;
      datao_q    <= bus.datai;
      hold_vld_q <= 1'b0;
      if (hold_vld_q) begin
        dvo_q    <= 1'b1;
        dtypeo_q <= hold_dtype_q;
        datao_q  <= hold_data_q;
        if (bus.dvi) ovf_q <= 1'b1;
      end else begin
        if (is_fs) begin
          mode_q  <= en_s2_q ? pack_mode : PACK_MODE_BYPASS;
          fc_q    <= fc_q + 1'b1;
          state_q <= ST_FRAME;
        end else if (is_hs) begin
          state_q <= ST_HEADER;
        end else if (is_fe || is_he) begin
          state_q <= ST_IDLE;
        end
        // Flush word goes out now; the FRAME_END token waits one cycle.
        if (acc_flush) begin
          dvo_q        <= 1'b1;
          dtypeo_q     <= pix_dtype_q;
          datao_q      <= acc_word;
          hold_vld_q   <= 1'b1;
          hold_dtype_q <= bus.dtypei;
          hold_data_q  <= bus.datai;
        end
        if (acc_push) begin
          dvo_q       <= acc_word_vld;
          datao_q     <= acc_word;
          pix_dtype_q <= bus.dtypei;
        end
`ifdef PACK_HDR_REWRITE_EN
        if (hdr_rw) datao_q <= (bus.datai & 16'hFFE0) | {11'b0, pack_imgtype(mode_q)};
`endif
      end
`ifdef PACK_HDR_REWRITE_EN
      if (is_hs || (state_q != ST_HEADER)) hdr_addr_q <= '0;
      else if (is_hdr)                     hdr_addr_q <= hdr_addr_q + 1'b1;
`endif
    end
  end

  assign bus.dvo     = dvo_q;
  assign bus.dtypeo  = dtypeo_q;
  assign bus.datao   = datao_q;
  assign frame_count = fc_q;
  assign active_mode = mode_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pack_nto16.sv
// tb_pack_nto16
//   Scoreboard bench for pack_nto16: expected output words are queued as
//   stimulus is driven and compared whenever the packer asserts dvo.
module tb_pack_nto16;
  import pack_nto16_pkg::*;

  localparam int HDR_ADDR = 3;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pack_mode = 2'd0;
  logic [15:0] frame_count;
  logic [1:0]  active_mode;
  logic        overflow;

  pack_nto16_if bus();

  pack_nto16 #(
    .HDR_IMGTYPE_ADDR (HDR_ADDR),
    .HDR_ADDR_WIDTH   (6),
    .FC_WIDTH         (16)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .enable      (enable),
    .pack_mode   (pack_mode),
    .bus         (bus),
    .frame_count (frame_count),
    .active_mode (active_mode),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  logic [19:0] sb_q[$];
  logic [19:0] sb_e;
  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetb && bus.dvo) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_dvo", 32'(bus.dvo), 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_word", {12'h0, bus.dtypeo, bus.datao}, {12'h0, sb_e});
      end
    end
  end

  task automatic expw(input dtype_t t, input logic [15:0] d);
    sb_q.push_back({t, d});
  endtask

  task automatic drive(input dtype_t t, input logic [15:0] d);
    bus.dvi    = 1'b1;
    bus.dtypei = t;
    bus.datai  = d;
    if (t == DTYPE_FRAME_START) exp_fc++;
    @(posedge clk);
    #1;
  endtask

  task automatic tok(input dtype_t t, input logic [15:0] d);
    expw(t, d);
    drive(t, d);
  endtask

  task automatic idle(input int n);
    bus.dvi    = 1'b0;
    bus.dtypei = '0;
    bus.datai  = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0]  emit10;
  int          words10;
  logic [15:0] hv;

  initial begin
    bus.dvi = 1'b0; bus.dtypei = '0; bus.datai = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dvo", 32'(bus.dvo), 0);
    chk("rst_dtypeo", 32'(bus.dtypeo), 0);
    chk("rst_datao", 32'(bus.datao), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_mode", 32'(active_mode), 0);
    chk("rst_ovf", 32'(overflow), 0);
    resetb = 1'b1;
    enable = 1'b1;
    idle(4);

    // 12-bit packing, no residual at frame end
    pack_mode = 2'd2;
    tok(DTYPE_FRAME_START, 16'h0);
    chk("t12_mode", 32'(active_mode), 2);
    chk("t12_fc", 32'(frame_count), 32'(exp_fc));
    drive(DTYPE_PIXEL, 16'h0ABC);
    chk("t12_dvo_first", 32'(bus.dvo), 0);
    expw(DTYPE_PIXEL, 16'hABCD); drive(DTYPE_PIXEL, 16'h0DEF);
    expw(DTYPE_PIXEL, 16'hEF12); drive(DTYPE_PIXEL, 16'h0123);
    expw(DTYPE_PIXEL, 16'h3456); drive(DTYPE_PIXEL, 16'h0456);
    tok(DTYPE_FRAME_END, 16'h0);
    chk("t12_fe_lat1", {27'h0, bus.dvo, bus.dtypeo}, {27'h0, 1'b1, DTYPE_FRAME_END});
    idle(2);
    chk("t12_sb_empty", sb_q.size(), 0);

    // 10-bit packing, 8 full-scale pixels -> 5 words
    pack_mode = 2'd1;
    emit10 = 8'b1101_1010;
    words10 = 0;
    tok(DTYPE_FRAME_START, 16'h0);
    for (int i = 0; i < 8; i++) begin
      if (emit10[i]) expw(DTYPE_PIXEL, 16'hFFFF);
      drive(DTYPE_PIXEL, 16'h03FF);
      chk("t10_dvo", 32'(bus.dvo), 32'(emit10[i]));
      words10 += int'(bus.dvo);
    end
    chk("t10_words", words10, 5);
    tok(DTYPE_FRAME_END, 16'h0);
    chk("t10_fe_lat1", {27'h0, bus.dvo, bus.dtypeo}, {27'h0, 1'b1, DTYPE_FRAME_END});
    idle(2);

    // 14-bit packing with a partial final word
    pack_mode = 2'd3;
    tok(DTYPE_FRAME_START, 16'h0);
    drive(DTYPE_PIXEL, 16'h3FFF);
    expw(DTYPE_PIXEL, 16'hFFFC); drive(DTYPE_PIXEL, 16'h0000);
    expw(4'h9, 16'h000A);        drive(4'h9, 16'h2AAA);
    expw(4'h9, 16'hAA80);
    tok(DTYPE_FRAME_END, 16'h0);
    chk("t14_flush", {11'h0, bus.dvo, bus.dtypeo, bus.datao}, {11'h0, 1'b1, 4'h9, 16'hAA80});
    idle(1);
    chk("t14_fe_lat2", {27'h0, bus.dvo, bus.dtypeo}, {27'h0, 1'b1, DTYPE_FRAME_END});
    idle(1);
    chk("t14_no_ovf", 32'(overflow), 0);

    // pack_mode change mid-frame is ignored until the next FRAME_START
    pack_mode = 2'd2;
    tok(DTYPE_FRAME_START, 16'h0);
    drive(DTYPE_PIXEL, 16'h0ABC);
    pack_mode = 2'd3;
    expw(DTYPE_PIXEL, 16'hABCD); drive(DTYPE_PIXEL, 16'h0DEF);
    chk("mchg_mode_held", 32'(active_mode), 2);
    expw(DTYPE_PIXEL, 16'hEF12); drive(DTYPE_PIXEL, 16'h0123);
    expw(DTYPE_PIXEL, 16'h3456); drive(DTYPE_PIXEL, 16'h0456);
    tok(DTYPE_FRAME_END, 16'h0);
    tok(DTYPE_FRAME_START, 16'h0);
    chk("mchg_mode_new", 32'(active_mode), 3);
    chk("mchg_fc", 32'(frame_count), 32'(exp_fc));
    tok(DTYPE_FRAME_END, 16'h0);
    idle(1);

    // Header image_type rewrite using the 12-bit mode
    pack_mode = 2'd2;
    tok(DTYPE_FRAME_START, 16'h0);
    tok(DTYPE_FRAME_END, 16'h0);
    tok(DTYPE_HEADER_START, 16'h0);
    for (int i = 0; i < HDR_ADDR; i++) tok(DTYPE_HEADER, 16'hAAAA);
`ifdef PACK_HDR_REWRITE_EN
    hv = 16'h1230;
`else
    hv = 16'h1234;
`endif
    expw(DTYPE_HEADER, hv);
    drive(DTYPE_HEADER, 16'h1234);
    chk("hdr_imgtype", 32'(bus.datao), 32'(hv));
    tok(DTYPE_HEADER, 16'h1234);
    tok(DTYPE_HEADER_END, 16'h0);
    idle(1);

    // Collision on the hold register: new input dropped, overflow sticks
    pack_mode = 2'd3;
    tok(DTYPE_FRAME_START, 16'h0);
    drive(DTYPE_PIXEL, 16'h3FFF);
    expw(DTYPE_PIXEL, 16'hFFFC);
    tok(DTYPE_FRAME_END, 16'h0);
    chk("ovf_before", 32'(overflow), 0);
    drive(DTYPE_PIXEL, 16'h0555);
    chk("ovf_held_fe", {27'h0, bus.dvo, bus.dtypeo}, {27'h0, 1'b1, DTYPE_FRAME_END});
    chk("ovf_set", 32'(overflow), 1);
    idle(3);
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset in the middle of a frame
    pack_mode = 2'd2;
    tok(DTYPE_FRAME_START, 16'h0);
    drive(DTYPE_PIXEL, 16'h0ABC);
    bus.dvi = 1'b0;
    #2;
    resetb = 1'b0;
    exp_fc = 0;
    #1;
    chk("mrst_dvo", 32'(bus.dvo), 0);
    chk("mrst_dtypeo", 32'(bus.dtypeo), 0);
    chk("mrst_datao", 32'(bus.datao), 0);
    chk("mrst_fc", 32'(frame_count), 0);
    chk("mrst_mode", 32'(active_mode), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    tok(DTYPE_PIXEL, 16'h0ABC);
    chk("mrst_bypass", {11'h0, bus.dvo, bus.dtypeo, bus.datao}, {11'h0, 1'b1, DTYPE_PIXEL, 16'h0ABC});

    // enable low at FRAME_START forces bypass for that frame
    enable = 1'b0;
    idle(3);
    pack_mode = 2'd2;
    tok(DTYPE_FRAME_START, 16'h0);
    chk("en0_mode", 32'(active_mode), 0);
    chk("en0_fc", 32'(frame_count), 32'(exp_fc));
    tok(DTYPE_PIXEL, 16'h0DEF);
    chk("en0_bypass", {11'h0, bus.dvo, bus.dtypeo, bus.datao}, {11'h0, 1'b1, DTYPE_PIXEL, 16'h0DEF});
    tok(DTYPE_FRAME_END, 16'h0);
    idle(4);

    chk("final_sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
